sync_scheduler_pipe: RTL and testbench



---
 rtl/sync_scheduler_pipe.sv | 190 +++++++++++++++++++
 tb/tb_sync_scheduler_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_scheduler_pipe.sv
// Pipelined FIFO-to-homography sync scheduler: issues coordinate queries, matches in-order returns.
// Optional macro SYNC_STATS_EN enables the saturating stat_* counters (tied to zero otherwise).
module sync_scheduler_pipe #(
   parameter int XW     = 10,
   parameter int YW     = 10,
   parameter int DEPTH  = 4,
   parameter int TO_CYC = 1023,
   parameter int CNT_W  = 16
) (
   input  logic                    clk_25,
   input  logic                    rst_n,
   input  logic [XW+YW+23:0]       q,
   input  logic                    rdempty,
   output logic                    rdclk,
   output logic                    rdreq,
   input  logic                    qready,
   output logic                    start,
   output logic [XW-1:0]           query_x,
   output logic [YW-1:0]           query_y,
   input  logic                    ready,
   input  logic [XW-1:0]           return_x,
   input  logic [YW-1:0]           return_y,
   input  logic [4:0]              r,
   input  logic [5:0]              g,
   input  logic [4:0]              b,
   output logic                    val,
   output logic [XW-1:0]           sync_x,
   output logic [YW-1:0]           sync_y,
   output logic [4:0]              dvi_r,
   output logic [5:0]              dvi_g,
   output logic [4:0]              dvi_b,
   output logic [4:0]              ccd_r,
   output logic [5:0]              ccd_g,
   output logic [4:0]              ccd_b,
   output logic                    debug,
   output logic                    timeout,
   output logic [$clog2(DEPTH):0]  pending,
   output logic [CNT_W-1:0]        stat_match,
   output logic [CNT_W-1:0]        stat_mismatch,
   output logic [CNT_W-1:0]        stat_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(TO_CYC + 1);
   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [TW-1:0] TO_P     = TW'(TO_CYC);
   localparam logic [TW-1:0] AGE_ONE  = TW'(1'b1);

   logic [XW-1:0] ent_x_r [DEPTH];
   logic [YW-1:0] ent_y_r [DEPTH];
   logic [4:0]    ent_r_r [DEPTH];
   logic [5:0]    ent_g_r [DEPTH];
   logic [4:0]    ent_b_r [DEPTH];

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [PW-1:0] occ_r;
   logic [TW-1:0] age_r;
   logic          rd_d1_r;

   logic [XW-1:0] q_x_s;
   logic [YW-1:0] q_y_s;
   logic          head_valid_s;
   logic          head_match_s;
   logic          pop_ret_s;
   logic          pop_to_s;
   logic          pop_s;
   logic          match_s;
   logic          mism_s;

   assign rdclk = clk_25;
   assign q_x_s = q[XW+YW+23:YW+24];
   assign q_y_s = q[YW+23:24];

   // occ_r counts written entries; reserved-but-unwritten slots only live in pending
   assign head_valid_s = (occ_r != {PW{1'b0}});
   assign head_match_s = (return_x == ent_x_r[rd_ptr_r]) && (return_y == ent_y_r[rd_ptr_r]);
   assign pop_ret_s    = ready && head_valid_s;
   assign pop_to_s     = !ready && head_valid_s && (age_r == TO_P);
   assign pop_s        = pop_ret_s || pop_to_s;
   assign match_s      = pop_ret_s && head_match_s;
   assign mism_s       = ready && !(head_valid_s && head_match_s);
   assign rdreq        = !rdempty && qready && (pending < DEPTH_P);

   // Issue pipeline, pending buffer, head ageing and registered result outputs
   always_ff @(posedge clk_25) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_x_r[i] <= {XW{1'b0}};
            ent_y_r[i] <= {YW{1'b0}};
            ent_r_r[i] <= 5'd0;
            ent_g_r[i] <= 6'd0;
            ent_b_r[i] <= 5'd0;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         occ_r    <= {PW{1'b0}};
         pending  <= {PW{1'b0}};
         age_r    <= {TW{1'b0}};
         rd_d1_r  <= 1'b0;
         start    <= 1'b0;
         query_x  <= {XW{1'b0}};
         query_y  <= {YW{1'b0}};
         val      <= 1'b0;
         debug    <= 1'b0;
         timeout  <= 1'b0;
         sync_x   <= {XW{1'b0}};
         sync_y   <= {YW{1'b0}};
         dvi_r    <= 5'd0;
         dvi_g    <= 6'd0;
         dvi_b    <= 5'd0;
         ccd_r    <= 5'd0;
         ccd_g    <= 6'd0;
         ccd_b    <= 5'd0;
      end else begin
         rd_d1_r <= rdreq;
         start   <= rd_d1_r;
         if (rd_d1_r) begin
            ent_x_r[wr_ptr_r] <= q_x_s;
            ent_y_r[wr_ptr_r] <= q_y_s;
            ent_r_r[wr_ptr_r] <= q[23:19];
            ent_g_r[wr_ptr_r] <= q[15:10];
            ent_b_r[wr_ptr_r] <= q[7:3];
            query_x           <= q_x_s;
            query_y           <= q_y_s;
            wr_ptr_r          <= wr_ptr_r + PTR_ONE;
         end
         val     <= match_s;
         debug   <= mism_s;
         timeout <= pop_to_s;
         if (match_s) begin
            sync_x <= ent_x_r[rd_ptr_r];
            sync_y <= ent_y_r[rd_ptr_r];
            dvi_r  <= ent_r_r[rd_ptr_r];
            dvi_g  <= ent_g_r[rd_ptr_r];
            dvi_b  <= ent_b_r[rd_ptr_r];
            ccd_r  <= r;
            ccd_g  <= g;
            ccd_b  <= b;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         pending <= pending + {{(PW-1){1'b0}}, rdreq} - {{(PW-1){1'b0}}, pop_s};
         occ_r   <= occ_r + {{(PW-1){1'b0}}, rd_d1_r} - {{(PW-1){1'b0}}, pop_s};
         // age restarts whenever a new entry takes over the head position
         if (pop_s || !head_valid_s) begin
            age_r <= {TW{1'b0}};
         end else begin
            age_r <= age_r + AGE_ONE;
         end
      end
   end

`ifdef SYNC_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1'b1);
      end
   endfunction

   // Saturating event counters
   always_ff @(posedge clk_25) begin
      if (!rst_n) begin
         stat_match    <= {CNT_W{1'b0}};
         stat_mismatch <= {CNT_W{1'b0}};
         stat_timeout  <= {CNT_W{1'b0}};
      end else begin
         if (match_s) begin
            stat_match <= sat_inc(stat_match);
         end
         if (mism_s) begin
            stat_mismatch <= sat_inc(stat_mismatch);
         end
         if (pop_to_s) begin
            stat_timeout <= sat_inc(stat_timeout);
         end
      end
   end
`else
   assign stat_match    = {CNT_W{1'b0}};
   assign stat_mismatch = {CNT_W{1'b0}};
   assign stat_timeout  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sync_scheduler_pipe.sv
`timescale 1ns/1ps
// Bench for sync_scheduler_pipe: queue-based reference model checked every cycle plus directed scenarios.
module tb_sync_scheduler_pipe;
   localparam int XW = 10, YW = 10, DEPTH = 4, TO_CYC = 20, CNT_W = 16;

   logic              clk_25 = 1'b0;
   logic              rst_n = 1'b0;
   logic [XW+YW+23:0] q = '0;
   logic              rdempty = 1'b1;
   logic              rdclk, rdreq;
   logic              qready = 1'b0;
   logic              start;
   logic [XW-1:0]     query_x, sync_x;
   logic [YW-1:0]     query_y, sync_y;
   logic              ready = 1'b0;
   logic [XW-1:0]     return_x = '0;
   logic [YW-1:0]     return_y = '0;
   logic [4:0]        r = '0, b = '0, dvi_r, dvi_b, ccd_r, ccd_b;
   logic [5:0]        g = '0, dvi_g, ccd_g;
   logic              val, debug, timeout;
   logic [2:0]        pending;
   logic [CNT_W-1:0]  stat_match, stat_mismatch, stat_timeout;

   sync_scheduler_pipe #(.XW(XW), .YW(YW), .DEPTH(DEPTH), .TO_CYC(TO_CYC), .CNT_W(CNT_W)) dut (
      .clk_25(clk_25), .rst_n(rst_n), .q(q), .rdempty(rdempty), .rdclk(rdclk), .rdreq(rdreq),
      .qready(qready), .start(start), .query_x(query_x), .query_y(query_y), .ready(ready),
      .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b), .val(val),
      .sync_x(sync_x), .sync_y(sync_y), .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
      .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b), .debug(debug), .timeout(timeout),
      .pending(pending), .stat_match(stat_match), .stat_mismatch(stat_mismatch),
      .stat_timeout(stat_timeout));

   always #20 clk_25 = ~clk_25;

   typedef struct { int x; int y; int r8; int g8; int b8; } rec_t;
   typedef struct { int x; int y; int dr; int dg; int db; } ent_t;

   rec_t fifo[$];
   ent_t ents[$];
   int   checks = 0, failures = 0;
   bit   chk_en = 1'b0;
   int   mcyc = 0, head_since = 0, m_res = 0, last_rdreq_cyc = -1;
   bit   m_sv = 1'b0;
   rec_t m_stage, env_word;
   int   env_pops = 0, env_done = 0;
   int   n_m = 0, n_mm = 0, n_to = 0;
   int   e_start = 0, e_qx = 0, e_qy = 0, e_val = 0, e_dbg = 0, e_to = 0;
   int   e_sx = 0, e_sy = 0, e_dr = 0, e_dg = 0, e_db = 0, e_cr = 0, e_cg = 0, e_cb = 0;
   int   start_cyc_q[$];
   int   val_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, mcyc);
      end
   endtask

   function automatic ent_t to_ent(input rec_t w);
      ent_t e;
      e.x = w.x; e.y = w.y; e.dr = w.r8 / 8; e.dg = w.g8 / 4; e.db = w.b8 / 8;
      return e;
   endfunction

   function automatic int stat_exp(input int n);
`ifdef SYNC_STATS_EN
      return (n > 65535) ? 65535 : n;
`else
      return 0 * n;
`endif
   endfunction

   // Reference model: advances one cycle on every rising edge using the pre-edge inputs
   always @(posedge clk_25) begin : model
      bit   rq_e, chg;
      ent_t e;
      rq_e = (rdempty == 1'b0) && (qready == 1'b1) && (m_res < DEPTH);
      if (chk_en) chk("rdreq", rdreq, rq_e);
      if (rdreq === 1'b1) last_rdreq_cyc = mcyc;
      e_start = 0; e_val = 0; e_dbg = 0; e_to = 0;
      if (rst_n == 1'b0) begin
         ents.delete(); m_sv = 1'b0; m_res = 0; n_m = 0; n_mm = 0; n_to = 0;
         e_qx = 0; e_qy = 0; e_sx = 0; e_sy = 0; e_dr = 0; e_dg = 0; e_db = 0;
         e_cr = 0; e_cg = 0; e_cb = 0;
      end else begin
         chg = 1'b0;
         if (ready == 1'b1) begin
            if (ents.size() == 0) begin
               e_dbg = 1; n_mm++;
            end else begin
               e = ents.pop_front(); chg = 1'b1; m_res--;
               if (int'(return_x) == e.x && int'(return_y) == e.y) begin
                  e_val = 1; n_m++;
                  e_sx = e.x; e_sy = e.y; e_dr = e.dr; e_dg = e.dg; e_db = e.db;
                  e_cr = int'(r); e_cg = int'(g); e_cb = int'(b);
               end else begin
                  e_dbg = 1; n_mm++;
               end
            end
         end else if (ents.size() > 0 && (mcyc - head_since) == TO_CYC) begin
            void'(ents.pop_front()); chg = 1'b1; m_res--; e_to = 1; n_to++;
         end
         if (m_sv) begin
            if (ents.size() == 0) chg = 1'b1;
            ents.push_back(to_ent(m_stage));
            e_start = 1; e_qx = m_stage.x; e_qy = m_stage.y;
         end
         if (chg) head_since = mcyc + 1;
         m_sv = rq_e && (fifo.size() > 0);
         if (m_sv) m_stage = fifo[0];
         if (rq_e) m_res++;
      end
      if (rdreq === 1'b1 && fifo.size() > 0) begin
         env_word = fifo.pop_front();
         env_pops++;
      end
      mcyc++;
   end

   // Per-cycle comparison of every registered output against the model
   always @(negedge clk_25) begin
      if (chk_en) begin
         chk("start", start, e_start);
         if (e_start == 1) begin
            chk("query_x", query_x, e_qx);
            chk("query_y", query_y, e_qy);
         end
         chk("val", val, e_val);
         chk("debug", debug, e_dbg);
         chk("timeout", timeout, e_to);
         chk("pending", pending, m_res);
         chk("sync_x", sync_x, e_sx);
         chk("sync_y", sync_y, e_sy);
         chk("dvi_rgb", {dvi_r, dvi_g, dvi_b}, (e_dr << 11) | (e_dg << 5) | e_db);
         chk("ccd_rgb", {ccd_r, ccd_g, ccd_b}, (e_cr << 11) | (e_cg << 5) | e_cb);
         chk("stat_match", stat_match, stat_exp(n_m));
         chk("stat_mismatch", stat_mismatch, stat_exp(n_mm));
         chk("stat_timeout", stat_timeout, stat_exp(n_to));
      end
      if (start === 1'b1) start_cyc_q.push_back(mcyc);
      if (val === 1'b1) val_cnt++;
   end

   task automatic step();
      @(posedge clk_25);
      @(negedge clk_25);
      if (env_pops != env_done) begin
         q = {XW'(env_word.x), YW'(env_word.y), 8'(env_word.r8), 8'(env_word.g8), 8'(env_word.b8)};
         env_done = env_pops;
      end
      rdempty = (fifo.size() == 0);
      #1;
   endtask

   task automatic push(input int x, input int y, input int r8, input int g8, input int b8);
      rec_t w;
      w.x = x; w.y = y; w.r8 = r8; w.g8 = g8; w.b8 = b8;
      fifo.push_back(w);
      rdempty = 1'b0;
   endtask

   task automatic ret(input int x, input int y, input int cr, input int cg, input int cb);
      ready = 1'b1; return_x = XW'(x); return_y = YW'(y);
      r = 5'(cr); g = 6'(cg); b = 5'(cb);
      step();
      ready = 1'b0;
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      while (start !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk("start_seen", start, 1);
   endtask

   initial begin
      int s_cyc, t_cyc, base;
      // reset
      qready = 1'b1;
      step();
      chk_en = 1'b1;
      step(); step();
      chk("rst_pending", pending, 0);
      chk("rst_val", val, 0);
      chk("rst_sync_x", sync_x, 0);
      chk("rst_start", start, 0);
      rst_n = 1'b1;
      step();

      // single record round trip
      push(100, 50, 8'hFF, 8'h80, 8'h08);
      wait_start(10);
      chk("t1_latency", mcyc - last_rdreq_cyc, 2);
      chk("t1_query_x", query_x, 100);
      chk("t1_query_y", query_y, 50);
      step();
      ret(100, 50, 3, 7, 1);
      chk("t1_val", val, 1);
      chk("t1_dvi_r", dvi_r, 5'h1F);
      chk("t1_dvi_g", dvi_g, 6'h20);
      chk("t1_dvi_b", dvi_b, 5'h01);
      chk("t1_ccd", {ccd_r, ccd_g, ccd_b}, {5'd3, 6'd7, 5'd1});
      chk("t1_sync", {sync_x, sync_y}, {10'd100, 10'd50});
      step(); step();
      chk("t1_val_once", val_cnt, 1);

      // six records, buffer fills at DEPTH
      base = start_cyc_q.size();
      for (int i = 0; i < 6; i++) push(200 + i, 10 + i, 16 * i, 255 - i, 3 * i);
      for (int i = 0; i < 10; i++) step();
      chk("t2_starts", start_cyc_q.size() - base, 4);
      chk("t2_back_to_back", start_cyc_q[base + 3] - start_cyc_q[base], 3);
      chk("t2_pending_full", pending, 4);
      chk("t2_rdreq_held", rdreq, 0);
      for (int i = 0; i < 4; i++) ret(200 + i, 10 + i, i, 2 * i, 31 - i);
      for (int i = 0; i < 4; i++) step();
      ret(204, 14, 4, 8, 27);
      ret(205, 15, 5, 10, 26);
      step();
      chk("t2_drained", pending, 0);
      chk("t2_last_sync_x", sync_x, 205);

      // mismatching return
      push(100, 50, 8'hFF, 8'h80, 8'h08);
      wait_start(10);
      step();
      chk("t3_pending_before", pending, 1);
      ret(101, 50, 9, 9, 9);
      chk("t3_debug", debug, 1);
      chk("t3_no_val", val, 0);
      chk("t3_sync_hold", sync_x, 205);
      chk("t3_pending_after", pending, 0);
`ifdef SYNC_STATS_EN
      chk("t3_stat_mismatch", stat_mismatch, 1);
`endif

      // head timeout, then a return exactly at the age limit
      push(300, 1, 8'h10, 8'h20, 8'h30);
      push(301, 2, 8'h40, 8'h50, 8'h60);
      wait_start(10);
      s_cyc = mcyc;
      for (int n = 0; n < 40 && timeout !== 1'b1; n++) step();
      chk("t4_timeout_seen", timeout, 1);
      chk("t4_timeout_latency", mcyc - s_cyc, TO_CYC + 1);
      t_cyc = mcyc;
      while (mcyc < t_cyc + TO_CYC) step();
      ret(301, 2, 6, 12, 18);
      chk("t4_val_at_limit", val, 1);
      chk("t4_no_timeout", timeout, 0);
      chk("t4_sync_x", sync_x, 301);

      // spurious ready, and qready low blocks reads
      ret(55, 66, 1, 1, 1);
      chk("t5_spurious_debug", debug, 1);
      chk("t5_pending_zero", pending, 0);
      qready = 1'b0;
      base = start_cyc_q.size();
      push(400, 7, 1, 2, 3);
      step(); step(); step();
      chk("t5_no_rdreq", rdreq, 0);
      chk("t5_no_start", start_cyc_q.size() - base, 0);

      // reset with reads in flight
      push(401, 8, 4, 5, 6);
      push(402, 9, 7, 8, 9);
      push(403, 10, 10, 11, 12);
      qready = 1'b1;
      step(); step(); step();
      chk("t6_pending3", pending, 3);
      chk("t6_rdreq_active", rdreq, 1);
      rst_n = 1'b0;
      step();
      chk("t6_rst_pending", pending, 0);
      chk("t6_rst_outs", {start, val, debug, timeout}, 4'd0);
      chk("t6_rst_query", {query_x, query_y}, 20'd0);
      chk("t6_rst_sync", {sync_x, sync_y, dvi_r, dvi_g, dvi_b}, 36'd0);
      chk("t6_rst_ccd", {ccd_r, ccd_g, ccd_b}, 16'd0);
      rst_n = 1'b1;
      qready = 1'b0;
      base = start_cyc_q.size();
      step(); step(); step();
      chk("t6_no_start", start_cyc_q.size() - base, 0);
      ret(401, 8, 1, 1, 1);
      chk("t6_spurious", debug, 1);
      chk("t6_val_zero", val, 0);
      chk("t6_pending", pending, 0);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
